// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, bus op codes, default geometry.
package mem_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 256;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Value loaded into the wait counter at acceptance (only used when wait > 0).
  function automatic logic [CNT_W-1:0] wait_load(input int unsigned wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, synchronous registered read (read port resets to 0).
module mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] store [DEPTH];

  // Contents intentionally have no reset; only the read register does.
  always_ff @(posedge clk) begin
    if (we) store[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= store[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder for the accumulator CPU strobe bus: IDLE/WAIT/RESP FSM, wait states, memReady pulse.
// Optional preload port enabled by defining MEM_LOADER_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData,
  output logic              memReady,
  output logic              memBusy
`ifdef MEM_LOADER_EN
  ,
  input  logic              loadEn,
  input  logic [DATA_W-1:0] loadData
`endif
);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wd_q;
  op_t               op_q;
  logic              busy_q;
  logic              ready_q;

  logic              load_act;
  logic              load_gate;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] ld_dat;

  logic              req;
  logic              accept;
  logic              commit;
  op_t               op_in;
  op_t               cur_op;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] cur_wd;

  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_idx;
  logic [DATA_W-1:0] arr_wd;

`ifdef MEM_LOADER_EN
  // Loading waits for IDLE so an in-flight transaction finishes first.
  assign load_gate = loadEn;
  assign load_act  = loadEn && (state == IDLE);
  assign ld_dat    = loadData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr <= '0;
    else if (!loadEn)  ptr <= '0;
    else if (load_act) ptr <= ptr + 1'b1;
  end

  assign memBusy = busy_q | loadEn;
`else
  assign load_gate = 1'b0;
  assign load_act  = 1'b0;
  assign ld_dat    = '0;
  assign ptr       = '0;
  assign memBusy   = busy_q;
`endif

  generate
    if (IDX_W < ADDR_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];
    end
  endgenerate

  assign req    = memRead | memWrite;
  assign op_in  = memWrite ? OP_WR : OP_RD;
  assign accept = (state == IDLE) && req && !load_gate;
  assign commit = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == '0));

  // With zero wait states the commit edge is the acceptance edge, so live bus values feed the array.
  always_comb begin
    cur_idx = idx_q;
    cur_wd  = wd_q;
    cur_op  = op_q;
    if (state == IDLE) begin
      cur_idx = address[IDX_W-1:0];
      cur_wd  = writeData;
      cur_op  = op_in;
    end
  end

  always_comb begin
    arr_we  = commit && (cur_op == OP_WR);
    arr_re  = commit && (cur_op == OP_RD);
    arr_idx = cur_idx;
    arr_wd  = cur_wd;
    if (load_act) begin
      arr_we  = 1'b1;
      arr_re  = 1'b0;
      arr_idx = ptr;
      arr_wd  = ld_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wd_q    <= '0;
      op_q    <= OP_RD;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q  <= address[IDX_W-1:0];
            wd_q   <= writeData;
            op_q   <= op_in;
            busy_q <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state   <= RESP;
              ready_q <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= wait_load(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign memReady = ready_q;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wd),
    .rdata (readData)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (0 and 3 wait states) against a transaction-level model.
module tb_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [11:0] addr      [2];
  logic [7:0]  wdata     [2];
  logic [7:0]  rdata     [2];
  logic        ready     [2];
  logic        busy      [2];
`ifdef MEM_LOADER_EN
  logic        load_en   [2];
  logic [7:0]  load_data [2];
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem_m  [2][256];
  bit         act    [2];
  int         acc    [2];
  bit         m_wr   [2];
  int         m_idx  [2];
  logic [7:0] m_wd   [2];
  logic [7:0] exp_rd [2];

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  mem_responder #(.DATA_W(8), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst[0]), .memRead(mem_read[0]), .memWrite(mem_write[0]),
    .address(addr[0]), .writeData(wdata[0]), .readData(rdata[0]),
    .memReady(ready[0]), .memBusy(busy[0])
`ifdef MEM_LOADER_EN
    , .loadEn(load_en[0]), .loadData(load_data[0])
`endif
  );

  mem_responder #(.DATA_W(8), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst[1]), .memRead(mem_read[1]), .memWrite(mem_write[1]),
    .address(addr[1]), .writeData(wdata[1]), .readData(rdata[1]),
    .memReady(ready[1]), .memBusy(busy[1])
`ifdef MEM_LOADER_EN
    , .loadEn(load_en[1]), .loadData(load_data[1])
`endif
  );

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, d, cyc, a, e);
    end
  endtask

  // Per-cycle compare: a transaction accepted at cycle A is busy over [A, A+W] and completes at A+W.
  always @(negedge clk) begin
    bit er, eb;
    for (int d = 0; d < 2; d++) begin
      er = act[d] && (cyc == acc[d] + wc(d));
      eb = act[d] && (cyc >= acc[d]) && (cyc <= acc[d] + wc(d));
`ifdef MEM_LOADER_EN
      eb = eb | load_en[d];
`endif
      if (er) begin
        if (m_wr[d]) mem_m[d][m_idx[d]] = m_wd[d];
        else         exp_rd[d] = mem_m[d][m_idx[d]];
        act[d] = 1'b0;
      end
      chk("ready", d, {31'd0, ready[d]}, {31'd0, er});
      chk("busy",  d, {31'd0, busy[d]},  {31'd0, eb});
      chk("rdata", d, {24'd0, rdata[d]}, {24'd0, exp_rd[d]});
    end
  end

  // Called and returns at posedge+#1; gap = idle cycles before raising the strobe.
  task automatic txn(input int d, input bit r, input bit w, input int a, input logic [7:0] wd,
                     input int gap, output int lat, output int nbusy, output logic [7:0] rv);
    repeat (gap) begin @(posedge clk); #1; end
    mem_read[d]  = r;
    mem_write[d] = w;
    addr[d]      = a[11:0];
    wdata[d]     = wd;
    m_wr[d]      = w;
    m_idx[d]     = a % 256;
    m_wd[d]      = wd;
    acc[d]       = cyc + 1;
    act[d]       = 1'b1;
    lat = -1; nbusy = 0; rv = 'x;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy[d] === 1'b1) nbusy++;
      if (ready[d] === 1'b1) begin
        lat = cyc - acc[d];
        rv  = rdata[d];
        break;
      end
      if (cyc >= acc[d]) begin
        addr[d]  = 12'($urandom);
        wdata[d] = 8'($urandom);
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL timeout dut%0d no memReady within 25 cycles", d);
      act[d] = 1'b0;
    end
    @(posedge clk); #1;
    mem_read[d]  = 1'b0;
    mem_write[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, cnt;
    logic [7:0] rv;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mem_read[d] = 1'b0; mem_write[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; act[d] = 1'b0; exp_rd[d] = 8'h00;
`ifdef MEM_LOADER_EN
      load_en[d] = 1'b0; load_data[d] = '0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_rdata", d, {24'd0, rdata[d]}, 32'h0);
      chk("reset_ready", d, {31'd0, ready[d]}, 32'h0);
      chk("reset_busy",  d, {31'd0, busy[d]},  32'h0);
      rst[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++) begin
      // Fill every word through the bus, with random upper address bits to exercise wrap.
      for (int i = 0; i < 256; i++)
        txn(d, 1'b0, 1'b1, i + 256 * $urandom_range(0, 15), 8'($urandom), 0, lat, nb, rv);

      txn(d, 1'b0, 1'b1, 'h010, 8'hA5, 1, lat, nb, rv);
      txn(d, 1'b1, 1'b0, 'h010, 8'h00, 0, lat, nb, rv);
      chk("rd_latency",  d, lat, (d == 0) ? 0 : 3);
      chk("busy_cycles", d, nb,  (d == 0) ? 1 : 4);
      chk("rd_A5",       d, {24'd0, rv}, 32'hA5);

      txn(d, 1'b1, 1'b1, 'h020, 8'h77, 0, lat, nb, rv);
      chk("both_keeps_rd", d, {24'd0, rv}, 32'hA5);
      txn(d, 1'b1, 1'b0, 'h020, 8'h00, 2, lat, nb, rv);
      chk("both_stored", d, {24'd0, rv}, 32'h77);

      txn(d, 1'b0, 1'b1, 'h105, 8'h3C, 0, lat, nb, rv);
      txn(d, 1'b1, 1'b0, 'h005, 8'h00, 0, lat, nb, rv);
      chk("wrap_rd", d, {24'd0, rv}, 32'h3C);
    end

    // Reset during the wait states of a write must discard it.
    txn(1, 1'b0, 1'b1, 'h030, 8'h11, 0, lat, nb, rv);
    @(posedge clk); #1;
    mem_write[1] = 1'b1; addr[1] = 12'h030; wdata[1] = 8'hFF;
    m_wr[1] = 1'b1; m_idx[1] = 'h30; m_wd[1] = 8'hFF; acc[1] = cyc + 1; act[1] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst[1] = 1'b1; act[1] = 1'b0; exp_rd[1] = 8'h00; mem_write[1] = 1'b0;
    cnt = 0;
    repeat (3) begin @(negedge clk); if (ready[1] === 1'b1) cnt++; end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (4) begin @(negedge clk); if (ready[1] === 1'b1) cnt++; end
    chk("rst_no_ready", 1, cnt, 0);
    @(posedge clk); #1;
    txn(1, 1'b1, 1'b0, 'h030, 8'h00, 0, lat, nb, rv);
    chk("rst_write_dropped", 1, {24'd0, rv}, 32'h11);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        int op;
        op = $urandom_range(0, 2);
        txn(d, op != 1, op != 0, int'($urandom_range(0, 4095)), 8'($urandom),
            $urandom_range(0, 2), lat, nb, rv);
      end
    end

`ifdef MEM_LOADER_EN
    load_en[0] = 1'b1; mem_read[0] = 1'b1; addr[0] = 12'h000;
    for (int i = 1; i <= 4; i++) begin
      load_data[0] = 8'(i);
      mem_m[0][i-1] = 8'(i);
      @(posedge clk); #1;
    end
    load_en[0] = 1'b0; mem_read[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      txn(0, 1'b1, 1'b0, i, 8'h00, 1, lat, nb, rv);
      chk("load_rd", 0, {24'd0, rv}, i + 1);
    end
    load_en[0] = 1'b1;
    load_data[0] = 8'h55; mem_m[0][0] = 8'h55; @(posedge clk); #1;
    load_data[0] = 8'h66; mem_m[0][1] = 8'h66; @(posedge clk); #1;
    load_en[0] = 1'b0;
    txn(0, 1'b1, 1'b0, 0, 8'h00, 1, lat, nb, rv);
    chk("reload_rd0", 0, {24'd0, rv}, 32'h55);
    txn(0, 1'b1, 1'b0, 2, 8'h00, 0, lat, nb, rv);
    chk("reload_rd2", 0, {24'd0, rv}, 32'h03);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
